io_reg_bank: RTL

//  Parametrised IO register bank; next generation of the fixed 8-in/18-out IO register cell.

---
 rtl/io_reg_bank_pkg.sv | 8 +
 rtl/io_reg_bank_if.sv | 19 +
 rtl/io_reg_bank_in_chan.sv | 47 ++++
 rtl/io_reg_bank.sv | 53 +++++
 4 files changed

// File: rtl/io_reg_bank_pkg.sv
// io_reg_pkg: shared limits and debounce counter width helper for io_reg_bank
package io_reg_pkg;
  localparam int SYNC_MAX = 3;
  localparam int DEB_MAX = 255;
  function automatic int cnt_w(input int deb);
    return (deb < 2) ? 1 : $clog2(deb + 1);
  endfunction
endpackage

// File: rtl/io_reg_bank_if.sv
// io_reg_bank_if: pad/fabric bus of io_reg_bank (A2F/IQZ/EVT_*/RISE_EN/FALL_EN/IRQ in, OQI/OQ_LD/F2A/F2A_DEF out); master=fabric+pads, slave=bank
interface io_reg_bank_if #(
  parameter int NUM_IN = 8,
  parameter int NUM_OUT = 18,
  parameter int NUM_DEF = 4
);
  logic [NUM_IN-1:0] A2F, IQZ, EVT_RISE, EVT_FALL, EVT_CLR, RISE_EN, FALL_EN;
  logic IRQ, OQ_LD;
  logic [NUM_OUT-1:0] OQI, F2A;
  logic [NUM_DEF-1:0] F2A_DEF;
  modport master (
    output A2F, EVT_CLR, RISE_EN, FALL_EN, OQI, OQ_LD,
    input IQZ, EVT_RISE, EVT_FALL, IRQ, F2A, F2A_DEF
  );
  modport slave (
    input A2F, EVT_CLR, RISE_EN, FALL_EN, OQI, OQ_LD,
    output IQZ, EVT_RISE, EVT_FALL, IRQ, F2A, F2A_DEF
  );
endinterface

// File: rtl/io_reg_bank_in_chan.sv
// io_in_chan: one input channel (clk, rst, a pad in, clr flag clear -> iqz debounced value, rise/fall sticky edge flags)
module io_in_chan
  import io_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic clr,
  output logic iqz,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_w(DEB_CYC);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic iqz_q, iqz_d, rise_q, rise_d, fall_q, fall_d, s, upd;
  assign s = sync_q[SYNC_STAGES-1];
  always_comb begin
    sync_d = (sync_q << 1) | SYNC_STAGES'(a);
    upd = (s != iqz_q) && (cnt_q == CW'(DEB_CYC - 1));
    cnt_d = (s == iqz_q || upd) ? '0 : cnt_q + 1'b1;
    iqz_d = upd ? s : iqz_q;
    rise_d = (upd & s) | (rise_q & ~clr);
    fall_d = (upd & ~s) | (fall_q & ~clr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      iqz_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      iqz_q <= iqz_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign iqz = iqz_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/io_reg_bank.sv
// io_reg_bank: IO register bank (IQC clock, QRT sync reset, bus: debounced inputs with edge flags and IRQ, loadable outputs, constant default pads)
module io_reg_bank
  import io_reg_pkg::*;
#(
  parameter int NUM_IN = 8,
  parameter int NUM_OUT = 18,
  parameter int NUM_DEF = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYC = 4,
  parameter logic [NUM_OUT-1:0] OUT_RST = '0,
  parameter logic [NUM_DEF-1:0] DEF_VAL = '0
) (
  input logic IQC,
  input logic QRT,
  io_reg_bank_if.slave bus
);
  if (SYNC_STAGES < 1 || SYNC_STAGES > SYNC_MAX || DEB_CYC < 1 || DEB_CYC > DEB_MAX) begin : g_bad_param
    $error("io_reg_bank: SYNC_STAGES must be 1..%0d and DEB_CYC 1..%0d", SYNC_MAX, DEB_MAX);
  end
  logic [NUM_IN-1:0] iqz, rise, fall;
  logic [NUM_OUT-1:0] f2a_q, f2a_d;
  logic irq_q, irq_d;
  for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
    io_in_chan #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYC(DEB_CYC)) u_chan (
      .clk(IQC),
      .rst(QRT),
      .a(bus.A2F[i]),
      .clr(bus.EVT_CLR[i]),
      .iqz(iqz[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
  always_comb begin
    f2a_d = bus.OQ_LD ? bus.OQI : f2a_q;
    irq_d = |((rise & bus.RISE_EN) | (fall & bus.FALL_EN));
  end
  always_ff @(posedge IQC) begin
    if (QRT) begin
      f2a_q <= OUT_RST;
      irq_q <= 1'b0;
    end else begin
      f2a_q <= f2a_d;
      irq_q <= irq_d;
    end
  end
  assign bus.IQZ = iqz;
  assign bus.EVT_RISE = rise;
  assign bus.EVT_FALL = fall;
  assign bus.IRQ = irq_q;
  assign bus.F2A = f2a_q;
  assign bus.F2A_DEF = DEF_VAL;
endmodule
